// File: rtl/alu_share_arb.sv
// alu_share_arb: two-port round-robin arbiter in front of a registered RV32I ALU.
// One operation in flight at a time; the result is held on a valid/ready channel.
module alu_share_arb #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            nreset_i,
   input  logic            r0_valid_i,
   output logic            r0_ready_o,
   input  logic [3:0]      r0_op_i,
   input  logic [XLEN-1:0] r0_a_i,
   input  logic [XLEN-1:0] r0_b_i,
   input  logic            r1_valid_i,
   output logic            r1_ready_o,
   input  logic [3:0]      r1_op_i,
   input  logic [XLEN-1:0] r1_a_i,
   input  logic [XLEN-1:0] r1_b_i,
   output logic            rsp_valid_o,
   input  logic            rsp_ready_i,
   output logic            rsp_id_o,
   output logic [XLEN-1:0] rsp_result_o,
   output logic            rsp_zero_o,
   output logic            rsp_illegal_o
);
   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
   state_t          state_q, state_d;
   logic            prio_q, prio_d, id_q, id_d;
   logic [3:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic            zero_q, zero_d, ill_q, ill_d;
   logic            g0, g1, alu_ill;
   logic [XLEN-1:0] alu;
   logic [4:0]      shamt;

   // prio only breaks ties; a lone requester always wins
   assign g0 = r0_valid_i & (~r1_valid_i | ~prio_q);
   assign g1 = r1_valid_i & (~r0_valid_i | prio_q);
   assign r0_ready_o = (state_q == IDLE) & g0;
   assign r1_ready_o = (state_q == IDLE) & g1;
   assign rsp_valid_o = state_q == RESP;
   assign rsp_id_o = id_q;
   assign rsp_result_o = res_q;
   assign rsp_zero_o = zero_q;
   assign rsp_illegal_o = ill_q;
   assign shamt = b_q[4:0];

   always_comb begin
      alu = '0;
      alu_ill = 1'b0;
      case (op_q)
         4'b0000: alu = a_q + b_q;
         4'b1000: alu = a_q - b_q;
         4'b0001: alu = a_q << shamt;
         4'b0101: alu = a_q >> shamt;
         4'b1101: alu = $signed(a_q) >>> shamt;
         4'b0010: alu = {{(XLEN-1){1'b0}}, $signed(a_q) < $signed(b_q)};
         4'b0011: alu = {{(XLEN-1){1'b0}}, a_q < b_q};
         4'b0100: alu = a_q ^ b_q;
         4'b0110: alu = a_q | b_q;
         4'b0111: alu = a_q & b_q;
         default: alu_ill = 1'b1;
      endcase
   end

   always_comb begin
      state_d = state_q;
      prio_d = prio_q;
      id_d = id_q;
      op_d = op_q;
      a_d = a_q;
      b_d = b_q;
      res_d = res_q;
      zero_d = zero_q;
      ill_d = ill_q;
      case (state_q)
         IDLE: if (g0 | g1) begin
            state_d = EXEC;
            id_d = g1;
            prio_d = ~g1;
            op_d = g1 ? r1_op_i : r0_op_i;
            a_d = g1 ? r1_a_i : r0_a_i;
            b_d = g1 ? r1_b_i : r0_b_i;
         end
         EXEC: begin
            state_d = RESP;
            res_d = alu;
            zero_d = alu == '0;
            ill_d = alu_ill;
         end
         RESP: state_d = rsp_ready_i ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         state_q <= IDLE;
         prio_q <= 1'b0;
         id_q <= 1'b0;
         op_q <= '0;
         a_q <= '0;
         b_q <= '0;
         res_q <= '0;
         zero_q <= 1'b0;
         ill_q <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q <= prio_d;
         id_q <= id_d;
         op_q <= op_d;
         a_q <= a_d;
         b_q <= b_d;
         res_q <= res_d;
         zero_q <= zero_d;
         ill_q <= ill_d;
      end
   end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: random and directed stimulus against an arithmetic reference
// of the RV32I ops plus a transaction-level model of grant order and response timing.
module tb_alu_share_arb;
   logic        clk = 1'b0, nreset = 1'b0;
   logic        r0_valid = 1'b0, r1_valid = 1'b0, rsp_ready = 1'b0;
   logic [3:0]  r0_op = '0, r1_op = '0;
   logic [31:0] r0_a = '0, r0_b = '0, r1_a = '0, r1_b = '0;
   logic        r0_ready, r1_ready, rsp_valid, rsp_id, rsp_zero, rsp_illegal;
   logic [31:0] rsp_result;
   int          n_tests = 0, n_fail = 0;
   int          prio_m = 0;

   always #5 clk = ~clk;

   alu_share_arb #(.XLEN(32)) dut (
      .clk_i(clk), .nreset_i(nreset),
      .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_op_i(r0_op), .r0_a_i(r0_a), .r0_b_i(r0_b),
      .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_op_i(r1_op), .r1_a_i(r1_a), .r1_b_i(r1_b),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
      .rsp_result_o(rsp_result), .rsp_zero_o(rsp_zero), .rsp_illegal_o(rsp_illegal)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // {illegal, result}
   function automatic logic [32:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         4'h0: return {1'b0, a + b};
         4'h8: return {1'b0, a - b};
         4'h1: return {1'b0, a << sh};
         4'h5: return {1'b0, a >> sh};
         4'hD: return {1'b0, (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0)};
         4'h2: return {1'b0, 31'h0, int'(a) < int'(b)};
         4'h3: return {1'b0, 31'h0, a < b};
         4'h4: return {1'b0, a ^ b};
         4'h6: return {1'b0, a | b};
         4'h7: return {1'b0, a & b};
         default: return {1'b1, 32'h0};
      endcase
   endfunction

   task automatic set_req(input int p, input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      if (p == 0) begin
         r0_valid = v; r0_op = op; r0_a = a; r0_b = b;
      end else begin
         r1_valid = v; r1_op = op; r1_a = a; r1_b = b;
      end
   endtask

   function automatic logic rdy(input int p);
      return p == 0 ? r0_ready : r1_ready;
   endfunction

   task automatic check_rsp(input int p, input logic [32:0] e);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_result", rsp_result, e[31:0]);
      check("rsp_id", rsp_id, p);
      check("rsp_zero", rsp_zero, e[31:0] == 0);
      check("rsp_illegal", rsp_illegal, e[32]);
   endtask

   // single requester p; bp cycles of held-off rsp_ready with the other port pushing
   task automatic run_op(input int p, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int bp);
      logic [32:0] e;
      int q;
      e = ref_alu(op, a, b);
      q = 1 - p;
      @(negedge clk);
      set_req(p, 1'b1, op, a, b);
      rsp_ready = bp == 0;
      #1 check("grant", rdy(p), 1);
      check("other_ready", rdy(q), 0);
      @(negedge clk);
      set_req(p, 1'b0, 4'h0, 0, 0);
      prio_m = q;
      #1 check("exec_rsp_valid", rsp_valid, 0);
      check("exec_ready", r0_ready | r1_ready, 0);
      @(negedge clk);
      if (bp > 0) set_req(q, 1'b1, 4'h7, 32'hDEAD_BEEF, 32'h1);
      for (int i = 0; i <= bp; i++) begin
         if (i > 0) @(negedge clk);
         if (i == bp) rsp_ready = 1'b1;
         #1 check_rsp(p, e);
         check("resp_ready", r0_ready | r1_ready, 0);
      end
      @(negedge clk);
      #1 check("idle_rsp_valid", rsp_valid, 0);
      if (bp > 0) begin
         check("idle_regrant", rdy(q), 1);
         set_req(q, 1'b0, 4'h0, 0, 0);
      end
   endtask

   // both requesters valid every cycle, always-ready consumer
   task automatic contention(input int n);
      logic [3:0]  op[2];
      logic [31:0] a[2], b[2];
      logic [32:0] e;
      int g;
      @(negedge clk);
      rsp_ready = 1'b1;
      for (int p = 0; p < 2; p++) begin
         op[p] = 4'($urandom); a[p] = $urandom; b[p] = $urandom;
         set_req(p, 1'b1, op[p], a[p], b[p]);
      end
      for (int k = 0; k < n; k++) begin
         if (k > 0) @(negedge clk);
         g = prio_m;
         e = ref_alu(op[g], a[g], b[g]);
         #1 check("cont_grant", rdy(g), 1);
         check("cont_other", rdy(1 - g), 0);
         @(negedge clk);
         prio_m = 1 - g;
         op[g] = 4'($urandom); a[g] = $urandom; b[g] = $urandom;
         set_req(g, 1'b1, op[g], a[g], b[g]);
         #1 check("cont_exec_ready", r0_ready | r1_ready, 0);
         @(negedge clk);
         #1 check_rsp(g, e);
         if (k == n - 1) begin
            set_req(0, 1'b0, 4'h0, 0, 0);
            set_req(1, 1'b0, 4'h0, 0, 0);
         end
      end
      @(negedge clk);
      #1 check("cont_end_valid", rsp_valid, 0);
   endtask

   initial begin
      logic [31:0] x;
      #2;
      check("rst_valid", rsp_valid, 0);
      check("rst_result", rsp_result, 0);
      check("rst_id", rsp_id, 0);
      check("rst_zero", rsp_zero, 0);
      check("rst_illegal", rsp_illegal, 0);
      check("rst_ready", r0_ready | r1_ready, 0);
      @(negedge clk);
      nreset = 1'b1;
      run_op(0, 4'h7, 32'hFFFF_0000, 32'h0F0F_0F0F, 0);
      run_op(1, 4'h8, 32'd5, 32'd7, 0);
      run_op(1, 4'hD, 32'h8000_0000, 32'h0000_0024, 0);
      run_op(1, 4'h2, 32'hFFFF_FFFF, 32'h1, 0);
      run_op(1, 4'h3, 32'hFFFF_FFFF, 32'h1, 0);
      x = $urandom;
      run_op(1, 4'h4, x, x, 0);
      run_op(0, 4'h9, 32'h1, 32'h1, 0);
      run_op(0, 4'h0, 32'h1234_5678, 32'h1111_1111, 5);
      contention(6);
      for (int i = 0; i < 40; i++) begin
         x = $urandom;
         run_op(int'($urandom_range(0, 1)), 4'($urandom), x,
                $urandom_range(0, 3) == 0 ? x : $urandom, int'($urandom_range(0, 3)));
      end
      // reset during EXEC discards the op and restores requester 0 priority
      @(negedge clk);
      set_req(0, 1'b1, 4'h0, 32'd5, 32'd6);
      rsp_ready = 1'b1;
      #1 check("mid_grant", r0_ready, 1);
      @(negedge clk);
      set_req(0, 1'b0, 4'h0, 0, 0);
      #1 nreset = 1'b0;
      prio_m = 0;
      #1 check("mid_rst_valid", rsp_valid, 0);
      check("mid_rst_result", rsp_result, 0);
      @(negedge clk);
      #1 check("mid_rst_hold", rsp_valid, 0);
      nreset = 1'b1;
      @(negedge clk);
      #1 check("mid_no_rsp", rsp_valid, 0);
      contention(4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
